// File: rtl/sa_ctrl_pkg.sv
// Shared types, default sizing and the skewed-index helper for the systolic-array load controller.
package sa_ctrl_pkg;

   localparam int DEF_NUM_REGS       = 16;
   localparam int DEF_ROW_LEN        = 8;
   localparam int DEF_DATA_W         = 16;
   localparam int DEF_IDX_W          = 5;
   localparam int DEF_FLUSH_CYCLES   = 2;
   localparam int DEF_COMPUTE_CYCLES = 30;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FLUSH,
      ST_COMPUTE,
      ST_DONE
   } state_t;

   // Register r is shifted by (r mod row_len) so the array sees a diagonal wavefront.
   function automatic int unsigned calc_idx(input int unsigned reg_c,
                                            input int unsigned elem_c,
                                            input int unsigned row_len);
      return elem_c + 1 + (reg_c % row_len);
   endfunction

endpackage

// File: rtl/sa_idx_gen.sv
// Register/element write counters and the combinational skewed IDX they imply.
module sa_idx_gen
   import sa_ctrl_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ROW_LEN  = DEF_ROW_LEN,
   parameter int IDX_W    = DEF_IDX_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        advance,
   output logic [$clog2(NUM_REGS)-1:0] reg_cnt,
   output logic [IDX_W-1:0]            idx,
   output logic                        last
);

   localparam int RS_W = $clog2(NUM_REGS);
   localparam int EL_W = $clog2(ROW_LEN);

   logic [EL_W-1:0] elem_cnt;
   logic            elem_wrap;

   assign elem_wrap = (elem_cnt == EL_W'(ROW_LEN - 1));
   assign last      = elem_wrap && (reg_cnt == RS_W'(NUM_REGS - 1));
   assign idx       = IDX_W'(calc_idx(32'(reg_cnt), 32'(elem_cnt), ROW_LEN));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         elem_cnt <= '0;
         reg_cnt  <= '0;
      end else if (clear) begin
         elem_cnt <= '0;
         reg_cnt  <= '0;
      end else if (advance) begin
         if (elem_wrap) begin
            elem_cnt <= '0;
            reg_cnt  <= reg_cnt + 1'b1;
         end else begin
            elem_cnt <= elem_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sa_load_controller.sv
// Load/flush/compute sequencer for SystolicArray; optional counters under `SA_CTRL_PERF_EN.
module sa_load_controller
   import sa_ctrl_pkg::*;
#(
   parameter int NUM_REGS       = DEF_NUM_REGS,
   parameter int ROW_LEN        = DEF_ROW_LEN,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int IDX_W          = DEF_IDX_W,
   parameter int FLUSH_CYCLES   = DEF_FLUSH_CYCLES,
   parameter int COMPUTE_CYCLES = DEF_COMPUTE_CYCLES
) (
   input  logic                        CLK,
   input  logic                        RSTN,
   input  logic                        START,
   input  logic                        ABORT,
   output logic                        BUSY,
   output logic                        DONE,
   input  logic                        IN_VALID,
   output logic                        IN_READY,
   input  logic [DATA_W-1:0]           IN_DATA,
   output logic                        SA_EN,
   output logic                        SA_RF_EN,
   output logic                        SA_WRITE,
   output logic [IDX_W-1:0]            SA_IDX,
   output logic [DATA_W-1:0]           SA_DIN,
   output logic [$clog2(NUM_REGS)-1:0] SA_REG_SELECT
`ifdef SA_CTRL_PERF_EN
   ,
   output logic [15:0]                 STALL_CNT,
   output logic [15:0]                 LAST_JOB_CYCLES
`endif
);

   localparam int RS_W    = $clog2(NUM_REGS);
   localparam int CYC_MAX = (COMPUTE_CYCLES > FLUSH_CYCLES) ? COMPUTE_CYCLES : FLUSH_CYCLES;
   localparam int CYC_W   = $clog2(CYC_MAX + 1);

   state_t            state, state_nxt;
   logic [CYC_W-1:0]  cyc_cnt;
   logic [RS_W-1:0]   reg_cnt;
   logic [IDX_W-1:0]  idx;
   logic              last, handshake, start_acc;
   logic              en_nxt, rf_nxt, wr_nxt, done_nxt;
   logic [IDX_W-1:0]  idx_nxt;
   logic [DATA_W-1:0] din_nxt;
   logic [RS_W-1:0]   rs_nxt;

   // The visible DONE cycle still counts as busy so a START there is ignored.
   assign BUSY      = (state != ST_IDLE) || DONE;
   assign IN_READY  = (state == ST_LOAD) && !ABORT;
   assign handshake = IN_VALID && IN_READY;
   assign start_acc = START && !BUSY && !ABORT;

   sa_idx_gen #(
      .NUM_REGS (NUM_REGS),
      .ROW_LEN  (ROW_LEN),
      .IDX_W    (IDX_W)
   ) u_idx_gen (
      .clk     (CLK),
      .rst_n   (RSTN),
      .clear   (ABORT || start_acc),
      .advance (handshake),
      .reg_cnt (reg_cnt),
      .idx     (idx),
      .last    (last)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt = state;
      en_nxt    = 1'b0;
      rf_nxt    = 1'b0;
      wr_nxt    = 1'b0;
      done_nxt  = 1'b0;
      din_nxt   = SA_DIN;
      idx_nxt   = SA_IDX;
      rs_nxt    = SA_REG_SELECT;
      case (state)
         ST_IDLE: if (start_acc) state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (handshake) begin
               en_nxt  = 1'b1;
               rf_nxt  = 1'b1;
               wr_nxt  = 1'b1;
               din_nxt = IN_DATA;
               idx_nxt = idx;
               rs_nxt  = reg_cnt;
               if (last) state_nxt = ST_FLUSH;
            end else begin
               rf_nxt = SA_RF_EN;
               wr_nxt = SA_WRITE;
            end
         end
         ST_FLUSH: begin
            en_nxt = 1'b1;
            rf_nxt = 1'b1;
            wr_nxt = 1'b1;
            if (cyc_cnt == CYC_W'(FLUSH_CYCLES - 1)) state_nxt = ST_COMPUTE;
         end
         ST_COMPUTE: begin
            en_nxt = 1'b1;
            rf_nxt = 1'b1;
            if (cyc_cnt == CYC_W'(COMPUTE_CYCLES - 1)) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (ABORT) begin
         state_nxt = ST_IDLE;
         en_nxt    = 1'b0;
         rf_nxt    = 1'b0;
         wr_nxt    = 1'b0;
         done_nxt  = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state         <= ST_IDLE;
         cyc_cnt       <= '0;
         SA_EN         <= 1'b0;
         SA_RF_EN      <= 1'b0;
         SA_WRITE      <= 1'b0;
         SA_IDX        <= '0;
         SA_DIN        <= '0;
         SA_REG_SELECT <= '0;
         DONE          <= 1'b0;
      end else begin
         state         <= state_nxt;
         cyc_cnt       <= (state_nxt != state) ? '0 :
                          ((state == ST_FLUSH) || (state == ST_COMPUTE)) ? cyc_cnt + 1'b1 : cyc_cnt;
         SA_EN         <= en_nxt;
         SA_RF_EN      <= rf_nxt;
         SA_WRITE      <= wr_nxt;
         SA_IDX        <= idx_nxt;
         SA_DIN        <= din_nxt;
         SA_REG_SELECT <= rs_nxt;
         DONE          <= done_nxt;
      end
   end

`ifdef SA_CTRL_PERF_EN
   logic [15:0] job_cnt;

   // job_cnt is 0 in the LOAD entry cycle; +1 includes the cycle DONE is visible.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         STALL_CNT       <= '0;
         LAST_JOB_CYCLES <= '0;
         job_cnt         <= '0;
      end else if (start_acc) begin
         STALL_CNT <= '0;
         job_cnt   <= '0;
      end else begin
         if ((state == ST_LOAD) && !handshake && (STALL_CNT != 16'hFFFF))
            STALL_CNT <= STALL_CNT + 16'd1;
         if (state != ST_IDLE)
            job_cnt <= job_cnt + 16'd1;
         if ((state == ST_DONE) && !ABORT)
            LAST_JOB_CYCLES <= job_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sa_load_controller.sv
// Directed self-checking bench for sa_load_controller.
module tb_sa_load_controller;

   logic        CLK = 1'b0;
   logic        RSTN, START, ABORT, IN_VALID;
   logic [15:0] IN_DATA;
   logic        BUSY, DONE, IN_READY, SA_EN, SA_RF_EN, SA_WRITE;
   logic [4:0]  SA_IDX;
   logic [15:0] SA_DIN;
   logic [3:0]  SA_REG_SELECT;
`ifdef SA_CTRL_PERF_EN
   logic [15:0] STALL_CNT, LAST_JOB_CYCLES;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   sa_load_controller dut (
      .CLK           (CLK),
      .RSTN          (RSTN),
      .START         (START),
      .ABORT         (ABORT),
      .BUSY          (BUSY),
      .DONE          (DONE),
      .IN_VALID      (IN_VALID),
      .IN_READY      (IN_READY),
      .IN_DATA       (IN_DATA),
      .SA_EN         (SA_EN),
      .SA_RF_EN      (SA_RF_EN),
      .SA_WRITE      (SA_WRITE),
      .SA_IDX        (SA_IDX),
      .SA_DIN        (SA_DIN),
      .SA_REG_SELECT (SA_REG_SELECT)
`ifdef SA_CTRL_PERF_EN
      ,
      .STALL_CNT       (STALL_CNT),
      .LAST_JOB_CYCLES (LAST_JOB_CYCLES)
`endif
   );

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset;
      RSTN     = 1'b0;
      START    = 1'b0;
      ABORT    = 1'b0;
      IN_VALID = 1'b0;
      IN_DATA  = 16'h0;
      repeat (2) @(posedge CLK);
      #1;
      RSTN = 1'b1;
   endtask

   // Leaves the bench in the LOAD entry cycle (cycle 0).
   task automatic start_job;
      START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   task automatic push_words(input int n);
      for (int k = 0; k < n; k++) begin
         IN_VALID = 1'b1;
         IN_DATA  = 16'((k % 8) + 1);
         tick();
      end
      IN_VALID = 1'b0;
   endtask

   task automatic test_reset;
      logic [30:0] outs;
      RSTN = 1'b0; START = 1'b0; ABORT = 1'b0; IN_VALID = 1'b1; IN_DATA = 16'hFFFF;
      #3;
      outs = {BUSY, DONE, IN_READY, SA_EN, SA_RF_EN, SA_WRITE, SA_IDX, SA_DIN, SA_REG_SELECT};
      checks++;
      if (outs !== 31'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h expected=0", outs);
      end
`ifdef SA_CTRL_PERF_EN
      checks++;
      if ({STALL_CNT, LAST_JOB_CYCLES} !== 32'h0) begin
         failures++;
         $display("FAIL reset_perf got=%h expected=0", {STALL_CNT, LAST_JOB_CYCLES});
      end
`endif
      do_reset();
   endtask

   task automatic test_basic;
      logic [4:0]  idx3 [8];
      logic [4:0]  idx12[8];
      logic [4:0]  exp_idx;
      logic [3:0]  exp_rs;
      logic [15:0] exp_din;
      logic [4:0]  exp_ctl, got_ctl;
      do_reset();
      IN_VALID = 1'b1;
      IN_DATA  = 16'h1;
      #1;
      checks++;
      if (IN_READY !== 1'b0) begin
         failures++;
         $display("FAIL idle_ready got=%b expected=0", IN_READY);
      end
      start_job();
      checks++;
      if ({BUSY, IN_READY, SA_EN} !== 3'b110) begin
         failures++;
         $display("FAIL load_entry busy/ready/en got=%b expected=110", {BUSY, IN_READY, SA_EN});
      end
      for (int k = 0; k < 128; k++) begin
         IN_DATA = 16'((k % 8) + 1);
         tick();
         exp_din = 16'((k % 8) + 1);
         exp_rs  = 4'(k / 8);
         exp_idx = 5'((k % 8) + 1 + ((k / 8) % 8));
         if (k / 8 == 3)  idx3[k % 8]  = SA_IDX;
         if (k / 8 == 12) idx12[k % 8] = SA_IDX;
         checks++;
         if ({SA_EN, SA_RF_EN, SA_WRITE, DONE} !== 4'b1110 || SA_DIN !== exp_din ||
             SA_REG_SELECT !== exp_rs || SA_IDX !== exp_idx) begin
            failures++;
            $display("FAIL write_%0d ctl=%b din=%h rs=%0d idx=%0d expected ctl=1110 din=%h rs=%0d idx=%0d",
                     k, {SA_EN, SA_RF_EN, SA_WRITE, DONE}, SA_DIN, SA_REG_SELECT, SA_IDX,
                     exp_din, exp_rs, exp_idx);
         end
      end
      IN_VALID = 1'b0;
      for (int e = 0; e < 8; e++) begin
         checks++;
         if (idx3[e] !== 5'(4 + e) || idx12[e] !== 5'(5 + e)) begin
            failures++;
            $display("FAIL skew_e%0d reg3=%0d reg12=%0d expected %0d %0d", e, idx3[e], idx12[e], 4 + e, 5 + e);
         end
      end
      // cycles 129..130 flush, 131..160 compute, 161 DONE, 162 idle
      for (int c = 129; c <= 162; c++) begin
         tick();
         got_ctl = {BUSY, DONE, SA_EN, SA_RF_EN, SA_WRITE};
         if (c <= 130)      exp_ctl = 5'b10111;
         else if (c <= 160) exp_ctl = 5'b10110;
         else if (c == 161) exp_ctl = 5'b11000;
         else               exp_ctl = 5'b00000;
         checks++;
         if (got_ctl !== exp_ctl) begin
            failures++;
            $display("FAIL job_cycle_%0d busy/done/en/rf/wr got=%b expected=%b", c, got_ctl, exp_ctl);
         end
         if (c <= 130) begin
            checks++;
            if (SA_DIN !== 16'h8 || SA_IDX !== 5'd15 || SA_REG_SELECT !== 4'd15) begin
               failures++;
               $display("FAIL flush_hold_%0d din=%h idx=%0d rs=%0d expected 8 15 15", c, SA_DIN, SA_IDX, SA_REG_SELECT);
            end
         end
`ifdef SA_CTRL_PERF_EN
         if (c == 161) begin
            checks++;
            if (LAST_JOB_CYCLES !== 16'd161 || STALL_CNT !== 16'd0) begin
               failures++;
               $display("FAIL perf_basic job=%0d stall=%0d expected 161 0", LAST_JOB_CYCLES, STALL_CNT);
            end
         end
`endif
      end
   endtask

   task automatic test_stall;
      logic [4:0]  exp_idx;
      logic [3:0]  exp_rs;
      logic [15:0] exp_din;
      int          k;
      do_reset();
      start_job();
      exp_idx = '0; exp_rs = '0; exp_din = '0;
      for (int c = 0; c < 255; c++) begin
         if (c % 2 == 0) begin
            k        = c / 2;
            IN_VALID = 1'b1;
            IN_DATA  = 16'((k % 8) + 1);
            exp_din  = 16'((k % 8) + 1);
            exp_rs   = 4'(k / 8);
            exp_idx  = 5'((k % 8) + 1 + ((k / 8) % 8));
         end else begin
            IN_VALID = 1'b0;
            IN_DATA  = 16'hDEAD;
         end
         tick();
         checks++;
         if (SA_EN !== (c % 2 == 0) || SA_WRITE !== 1'b1 || SA_DIN !== exp_din ||
             SA_REG_SELECT !== exp_rs || SA_IDX !== exp_idx) begin
            failures++;
            $display("FAIL stall_cycle_%0d en=%b wr=%b din=%h rs=%0d idx=%0d expected en=%0d wr=1 din=%h rs=%0d idx=%0d",
                     c + 1, SA_EN, SA_WRITE, SA_DIN, SA_REG_SELECT, SA_IDX, (c % 2 == 0), exp_din, exp_rs, exp_idx);
         end
      end
      IN_VALID = 1'b0;
      for (int c = 256; c <= 289; c++) begin
         tick();
         checks++;
         if (DONE !== (c == 288) || BUSY !== (c <= 288)) begin
            failures++;
            $display("FAIL stall_done_cycle_%0d done=%b busy=%b expected %0d %0d", c, DONE, BUSY, c == 288, c <= 288);
         end
`ifdef SA_CTRL_PERF_EN
         if (c == 288) begin
            checks++;
            if (STALL_CNT !== 16'd127 || LAST_JOB_CYCLES !== 16'd288) begin
               failures++;
               $display("FAIL perf_stall stall=%0d job=%0d expected 127 288", STALL_CNT, LAST_JOB_CYCLES);
            end
         end
`endif
      end
   endtask

   task automatic test_abort;
      do_reset();
      start_job();
      push_words(50);
      IN_VALID = 1'b1;
      IN_DATA  = 16'h0BAD;
      ABORT    = 1'b1;
      #1;
      checks++;
      if (IN_READY !== 1'b0 || BUSY !== 1'b1) begin
         failures++;
         $display("FAIL abort_ready ready=%b busy=%b expected 0 1", IN_READY, BUSY);
      end
      tick();
      ABORT = 1'b0;
      checks++;
      if ({BUSY, DONE, SA_EN, SA_RF_EN, SA_WRITE} !== 5'b0) begin
         failures++;
         $display("FAIL abort_idle busy/done/en/rf/wr got=%b expected=00000", {BUSY, DONE, SA_EN, SA_RF_EN, SA_WRITE});
      end
      // word 49 is reg 6 elem 1: DIN 2, IDX 2+6
      checks++;
      if (SA_DIN !== 16'h2 || SA_REG_SELECT !== 4'd6 || SA_IDX !== 5'd8) begin
         failures++;
         $display("FAIL abort_hold din=%h rs=%0d idx=%0d expected 2 6 8", SA_DIN, SA_REG_SELECT, SA_IDX);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({BUSY, DONE, IN_READY, SA_EN} !== 4'b0) begin
            failures++;
            $display("FAIL abort_stays_idle_%0d busy/done/ready/en got=%b expected=0000", i, {BUSY, DONE, IN_READY, SA_EN});
         end
      end
      IN_DATA = 16'h0055;
      start_job();
      tick();
      checks++;
      if (SA_EN !== 1'b1 || SA_REG_SELECT !== 4'd0 || SA_IDX !== 5'd1 || SA_DIN !== 16'h0055) begin
         failures++;
         $display("FAIL abort_restart en=%b rs=%0d idx=%0d din=%h expected 1 0 1 0055", SA_EN, SA_REG_SELECT, SA_IDX, SA_DIN);
      end
      IN_VALID = 1'b0;
      ABORT    = 1'b1;
      tick();
      ABORT = 1'b0;
   endtask

   task automatic test_start_during_compute;
      int dones;
      do_reset();
      start_job();
      push_words(128);
      dones = 0;
      for (int c = 129; c <= 170; c++) begin
         START = (c == 140);
         tick();
         if (DONE === 1'b1) dones++;
         checks++;
         if (BUSY !== (c <= 161)) begin
            failures++;
            $display("FAIL start_in_compute_busy_%0d got=%b expected=%0d", c, BUSY, c <= 161);
         end
      end
      START = 1'b0;
      checks++;
      if (dones != 1) begin
         failures++;
         $display("FAIL start_in_compute_done_count got=%0d expected=1", dones);
      end
   endtask

   task automatic test_rstn_flush;
      do_reset();
      start_job();
      push_words(128);
      tick();
      checks++;
      if ({SA_EN, SA_WRITE, BUSY} !== 3'b111) begin
         failures++;
         $display("FAIL flush_precond en/wr/busy got=%b expected=111", {SA_EN, SA_WRITE, BUSY});
      end
      #2;
      RSTN = 1'b0;
      #1;
      checks++;
      if ({BUSY, DONE, IN_READY, SA_EN, SA_RF_EN, SA_WRITE, SA_IDX, SA_DIN, SA_REG_SELECT} !== 31'h0) begin
         failures++;
         $display("FAIL async_reset_flush got=%h expected=0",
                  {BUSY, DONE, IN_READY, SA_EN, SA_RF_EN, SA_WRITE, SA_IDX, SA_DIN, SA_REG_SELECT});
      end
      #2;
      RSTN     = 1'b1;
      IN_VALID = 1'b1;
      IN_DATA  = 16'h0077;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({BUSY, DONE, IN_READY, SA_EN} !== 4'b0) begin
            failures++;
            $display("FAIL post_reset_idle_%0d busy/done/ready/en got=%b expected=0000", i, {BUSY, DONE, IN_READY, SA_EN});
         end
      end
      start_job();
      tick();
      checks++;
      if (SA_EN !== 1'b1 || SA_REG_SELECT !== 4'd0 || SA_IDX !== 5'd1 || SA_DIN !== 16'h0077) begin
         failures++;
         $display("FAIL post_reset_restart en=%b rs=%0d idx=%0d din=%h expected 1 0 1 0077", SA_EN, SA_REG_SELECT, SA_IDX, SA_DIN);
      end
      IN_VALID = 1'b0;
      ABORT    = 1'b1;
      tick();
      ABORT = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_abort();
      test_start_during_compute();
      test_rstn_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "time limit");
   end

endmodule
